// File: rtl/bonus_ship_pkg.sv
// Shared types and constants for the bonus ship controller.
package bonus_ship_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FLY     = 2'd2,
    ST_EXPLODE = 2'd3
  } ship_state_e;

  // LFSR seed and Fibonacci tap mask (taps 16,14,13,11 -> bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Award table indexed by the two low bits of the shot counter: 50,100,150,300.
  localparam logic [3:0][8:0] SCORE_TABLE = {9'd300, 9'd150, 9'd100, 9'd50};

  function automatic logic [8:0] score_for(input logic [1:0] idx);
    return SCORE_TABLE[idx];
  endfunction

endpackage

// File: rtl/random_lfsr.sv
// 16-bit Fibonacci LFSR with enable and synchronous seed load.
module random_lfsr
  import bonus_ship_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // Next value: explicit load, escape from the all-zero lock-up, or shift.
  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (lfsr_q == 16'd0) begin
      lfsr_d = LFSR_SEED;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  // State register; reset restores the fixed seed.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bonus_ship_controller.sv
// Bonus (mystery) ship controller: random launch delay, horizontal flight,
// explosion on hit and a one-cycle score award. Position feeds the bitmap chain.
module bonus_ship_controller
  import bonus_ship_pkg::*;
#(
  parameter int SCREEN_WIDTH   = 640,
  parameter int SHIP_WIDTH     = 64,
  parameter int SHIP_Y         = 40,
  parameter int SPEED          = 2,
  parameter int MIN_DELAY      = 600,
  parameter int EXPLODE_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        playGame,
  input  logic        collision,
  input  logic        playerShot,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        shipVisible,
  output logic        explosionActive,
  output logic        scoreValid,
  output logic [8:0]  scoreValue
);

  localparam logic [10:0] RIGHT_X   = 11'(SCREEN_WIDTH - SHIP_WIDTH);
  localparam logic [11:0] RIGHT_X12 = 12'(SCREEN_WIDTH - SHIP_WIDTH);
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [15:0] DELAY_MIN = 16'(MIN_DELAY);
  localparam logic [15:0] EXPL_LAST = 16'(EXPLODE_FRAMES - 1);

  ship_state_e state_q, state_d;
  logic [10:0] x_q, x_d;
  logic        dir_q, dir_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] expl_cnt_q, expl_cnt_d;
  logic [7:0]  shot_cnt_q, shot_cnt_d;
  logic        ship_visible_q, ship_visible_d;
  logic        explosion_active_q, explosion_active_d;
  logic        score_valid_q, score_valid_d;
  logic [8:0]  score_value_q, score_value_d;

  logic [15:0] lfsr;
  logic [15:0] new_wait;
  logic        unused_bits;

  random_lfsr u_lfsr (
    .clk     (clk),
    .reset_i (reset),
    .en_i    (1'b1),
    .load_i  (1'b0),
    .seed_i  (LFSR_SEED),
    .lfsr_o  (lfsr)
  );

  assign new_wait    = DELAY_MIN + {8'd0, lfsr[7:0]};
  assign unused_bits = ^{lfsr[15:8], shot_cnt_q[7:2]};

  // Next-state, datapath and registered-output logic for the flight FSM.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    dir_d         = dir_q;
    wait_cnt_d    = wait_cnt_q;
    expl_cnt_d    = expl_cnt_q;
    shot_cnt_d    = shot_cnt_q + {7'd0, playerShot};
    score_valid_d = 1'b0;
    score_value_d = score_value_q;

    unique case (state_q)
      ST_IDLE: begin
        if (playGame) begin
          state_d    = ST_WAIT;
          wait_cnt_d = new_wait;
        end
      end
      ST_WAIT: begin
        if (startOfFrame) begin
          if (wait_cnt_q == 16'd0) begin
            state_d = ST_FLY;
            dir_d   = lfsr[0];
            x_d     = lfsr[0] ? RIGHT_X : 11'd0;
          end else begin
            wait_cnt_d = wait_cnt_q - 16'd1;
          end
        end
      end
      ST_FLY: begin
        // A hit beats the edge check so the player always gets the award.
        if (collision) begin
          state_d       = ST_EXPLODE;
          expl_cnt_d    = EXPL_LAST;
          score_valid_d = 1'b1;
          score_value_d = score_for(shot_cnt_q[1:0]);
        end else if (startOfFrame) begin
          if (!dir_q) begin
            if (({1'b0, x_q} + {1'b0, STEP}) > RIGHT_X12) begin
              state_d    = ST_WAIT;
              wait_cnt_d = new_wait;
            end else begin
              x_d = x_q + STEP;
            end
          end else begin
            if (x_q < STEP) begin
              state_d    = ST_WAIT;
              wait_cnt_d = new_wait;
            end else begin
              x_d = x_q - STEP;
            end
          end
        end
      end
      ST_EXPLODE: begin
        if (startOfFrame) begin
          if (expl_cnt_q == 16'd0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = new_wait;
          end else begin
            expl_cnt_d = expl_cnt_q - 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving the game abandons whatever the ship was doing, award included.
    if (!playGame) begin
      state_d       = ST_IDLE;
      score_valid_d = 1'b0;
    end

    ship_visible_d     = (state_d == ST_FLY);
    explosion_active_d = (state_d == ST_EXPLODE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      x_q                <= 11'd0;
      dir_q              <= 1'b0;
      wait_cnt_q         <= 16'd0;
      expl_cnt_q         <= 16'd0;
      shot_cnt_q         <= 8'd0;
      ship_visible_q     <= 1'b0;
      explosion_active_q <= 1'b0;
      score_valid_q      <= 1'b0;
      score_value_q      <= 9'd0;
    end else begin
      state_q            <= state_d;
      x_q                <= x_d;
      dir_q              <= dir_d;
      wait_cnt_q         <= wait_cnt_d;
      expl_cnt_q         <= expl_cnt_d;
      shot_cnt_q         <= shot_cnt_d;
      ship_visible_q     <= ship_visible_d;
      explosion_active_q <= explosion_active_d;
      score_valid_q      <= score_valid_d;
      score_value_q      <= score_value_d;
    end
  end

  assign topLeftX        = x_q;
  assign topLeftY        = 11'(SHIP_Y);
  assign shipVisible     = ship_visible_q;
  assign explosionActive = explosion_active_q;
  assign scoreValid      = score_valid_q;
  assign scoreValue      = score_value_q;

endmodule

// File: doc/bonus_ship_controller.md
BONUS_SHIP_CONTROLLER -- requirements
Module: bonus_ship_controller

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640: visible width in pixels.
REQ-002 Parameter SHIP_WIDTH, default 64: bonus ship bitmap width in pixels.
REQ-003 Parameter SHIP_Y, default 40: fixed top-left Y of the ship.
REQ-004 Parameter SPEED, default 2: pixels moved per frame.
REQ-005 Parameter MIN_DELAY, default 600: minimum frames between flights.
REQ-006 Parameter EXPLODE_FRAMES, default 30: frames the explosion is shown.
REQ-007 Port clk, input, 1: system clock; one clock, all logic on its rising edge.
REQ-008 Port reset, input, 1: reset is synchronous and active-high.
REQ-009 Port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-010 Port playGame, input, 1: game running; low forces idle.
REQ-011 Port collision, input, 1: one-cycle pulse, player missile hit the ship.
REQ-012 Port playerShot, input, 1: one-cycle pulse per player missile fired.
REQ-013 Port topLeftX, output, 11: ship top-left X.
REQ-014 Port topLeftY, output, 11: ship top-left Y, always SHIP_Y.
REQ-015 Port shipVisible, output, 1: ship bitmap enabled.
REQ-016 Port explosionActive, output, 1: explosion graphic enabled.
REQ-017 Port scoreValid, output, 1: one-cycle award pulse.
REQ-018 Port scoreValue, output, 9: award amount, qualified by scoreValid.

Function
REQ-019 States: IDLE, WAIT, FLY, EXPLODE; all outputs registered; every transition takes effect the cycle after its cause.
REQ-020 IDLE: exits to WAIT when playGame=1, loading waitCnt = MIN_DELAY + lfsr[7:0].
REQ-021 WAIT: waitCnt decrements by 1 on each startOfFrame; when startOfFrame arrives with waitCnt=0, go to FLY.
REQ-022 On FLY entry: direction = lfsr[0]; 0 = left-to-right, topLeftX=0; 1 = right-to-left, topLeftX=SCREEN_WIDTH-SHIP_WIDTH (576).
REQ-023 FLY: on startOfFrame, topLeftX moves by SPEED in the flight direction.
REQ-024 Left-to-right edge: if topLeftX+SPEED > SCREEN_WIDTH-SHIP_WIDTH at startOfFrame, go to WAIT (new random waitCnt) with no move.
REQ-025 Right-to-left edge: if topLeftX < SPEED at startOfFrame, go to WAIT with no move; X never wraps below 0.
REQ-026 FLY + collision: go to EXPLODE, freeze topLeftX, pulse scoreValid for exactly one cycle with scoreValue = table[shotCnt[1:0]], table = {50,100,150,300}.
REQ-027 Collision and an edge condition in the same cycle: collision wins (EXPLODE, award given).
REQ-028 Collision outside FLY: ignored; no award.
REQ-029 EXPLODE: explCnt loaded with EXPLODE_FRAMES-1 and decremented per startOfFrame; at 0 with startOfFrame, go to WAIT with new random waitCnt.
REQ-030 shipVisible=1 only in FLY; explosionActive=1 only in EXPLODE.
REQ-031 shotCnt: 8-bit, increments on playerShot, wraps 255->0; cleared only by reset.
REQ-032 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock, never all-zero.
REQ-033 playGame low in any state: next cycle IDLE, shipVisible=0, explosionActive=0, no award; any pending flight is abandoned.

Reset
REQ-034 On reset: state IDLE, topLeftX=0, topLeftY=SHIP_Y, shipVisible=0, explosionActive=0, scoreValid=0, scoreValue=0, shotCnt=0, waitCnt=0, explCnt=0, lfsr=16'hACE1.
REQ-035 Reset mid-flight or mid-explosion: outputs take their reset values in the next cycle; no score pulse is emitted.

Structure
REQ-036 Package bonus_ship_pkg holds the state enum, the score table, LFSR seed and tap constants.
REQ-037 Sub-module random_lfsr (16-bit, enable, synchronous seed load) provides the random source.
REQ-038 The controller keeps no bitmap; topLeftX/Y feed the existing square-object/bitmap chain.

Verification
REQ-039 reset, then playGame=1, lfsr[7:0]=0x10 at load, frames pulsed -> FLY entered after 616+1 frames; shipVisible rises one cycle after that startOfFrame.
REQ-040 Left-to-right flight, SPEED=2 -> X=0,2,...,576 over 289 frames; next frame: WAIT, shipVisible=0.
REQ-041 3 playerShot pulses, then collision in FLY at X=100 -> scoreValid one cycle, scoreValue=300; explosionActive for 30 frames; X held at 100.
REQ-042 Collision on the same cycle as the right-to-left edge (X=0 on startOfFrame) -> EXPLODE and award, not WAIT.
REQ-043 playGame dropped mid-EXPLODE -> next cycle IDLE, explosionActive=0, no further scoreValid.
REQ-044 collision pulse during WAIT -> no scoreValid, state stays WAIT.
